rv_multicycle_ctrl: RTL and testbench
=====================================

# rv_multicycle_ctrl

Multi-cycle control unit for the RV32I core. It owns the PC and instruction register and sequences each instruction through fetch, decode, execute, memory and writeback. Each state drives the immediate-type select to the immediate generator, the ALU operand/op selects, the memory request strobes and the register-file write enable. It sits between the instruction/data memory ports and the existing combinational datapath blocks.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- o_imem_req  out  1  instruction fetch request.
- o_pc  out  32  current PC; also the fetch address.
- i_imem_ack  in  1  fetch complete; i_imem_rdata valid this cycle.
- i_imem_rdata  in  32  fetched instruction.
- o_instr  out  32  instruction register, feeds the immediate generator and regfile addresses.
- o_imm_sel  out  3  immediate type: 000 I, 001 I-shamt, 010 S, 011 B, 100 J, 101 U.
- i_imm  in  32  immediate from the generator.
- o_alu_a_sel  out  1  0 = rs1, 1 = PC.
- o_alu_b_sel  out  1  0 = rs2, 1 = imm.
- o_alu_op  out  4  {funct7[5], funct3} for OP; {0, funct3} for OP-IMM except SRAI/SRLI, which use {funct7[5], funct3}; 4'b0000 (ADD) otherwise.
- i_alu_result  in  32  ALU output, used for the JALR target.
- i_br_taken  in  1  branch comparator result for the current instruction.
- o_dmem_req  out  1  data memory request.
- o_dmem_we  out  1  1 = store.
- i_dmem_ack  in  1  data access complete.
- o_rd_we  out  1  register-file write strobe, one cycle.
- o_wb_sel  out  2  00 ALU, 01 memory, 10 PC+4, 11 imm (LUI).
- o_retire  out  1  one-cycle pulse on the final cycle of every instruction.
- o_illegal  out  1  illegal-instruction flag (see Configuration).

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- FETCH: o_imem_req=1 until i_imem_ack. On ack, load IR and go to DECODE. An ack with req low is ignored.
- DECODE: classify opcode and hold o_imm_sel stable from DECODE through the last state of the instruction.
  - 0110111 LUI → U; 0010111 AUIPC → U; 1101111 JAL → J; 1100111 JALR → I; 1100011 BRANCH → B; 0000011 LOAD → I; 0100011 STORE → S.
  - 0010011 OP-IMM → I, or I-shamt for funct3 001/101; 0110011 OP → 000; 0001111 FENCE → NOP.
  - Any other opcode is illegal.
- EXEC: drive ALU selects. AUIPC uses a=PC, b=imm. LOAD/STORE use a=rs1, b=imm (address). JALR uses a=rs1, b=imm.
  - BRANCH, and FENCE/NOP: update PC, retire, go to FETCH.
  - LOAD/STORE: go to MEM.
  - All others: go to WB.
- MEM: o_dmem_req=1, o_dmem_we=STORE, held until i_dmem_ack.
  - STORE: update PC, retire, go to FETCH.
  - LOAD: go to WB.
- WB: o_rd_we=1 for one cycle with o_wb_sel per class: LUI 11, JAL/JALR 10, LOAD 01, others 00. Update PC, retire, go to FETCH.
- PC update, applied at retire:
  - JAL: PC+imm.
  - JALR: i_alu_result & ~32'h1.
  - BRANCH: PC+imm if i_br_taken, else PC+4.
  - Otherwise: PC+4.
  - All arithmetic is mod 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
- Writes with rd=x0 still pulse o_rd_we; the regfile discards them.

## Timing
- Reset (asynchronous, immediate on i_rst_n low): state=FETCH, PC=RESET_PC, IR=32'h0000_0013 (NOP).
  - All strobes (o_imem_req, o_dmem_req, o_dmem_we, o_rd_we, o_retire, o_illegal) are 0.
  - All selects are 0.
- First cycle after reset deassertion: o_imem_req=1.
- Latency with zero-wait memory (ack in the first request cycle):
  - OP/OP-IMM/LUI/AUIPC/JAL/JALR: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - BRANCH/FENCE: 3 cycles.
  - Each wait cycle on imem or dmem adds 1.
- o_pc changes only on the cycle after o_retire. o_instr changes only on the cycle after an accepted imem ack.
- Reset during any state, including a pending memory request, aborts the instruction with no retire and no rd write. The request drops immediately.

## Configuration
- ILLEGAL_TRAP_EN defined: an illegal opcode in DECODE goes to TRAP.
  - TRAP holds o_illegal=1, asserts no strobes, never retires, and is left only by reset.
- ILLEGAL_TRAP_EN undefined: an illegal opcode executes as a NOP (3 cycles, PC+4, retire). o_illegal is tied to 0 and the TRAP state is not built.

## Test plan
- Reset with RESET_PC=32'h100, imem ack immediate, instr 32'h00500093 (ADDI x1,x0,5) → o_imm_sel=000, o_alu_b_sel=1, o_rd_we with o_wb_sel=00 in cycle 4, o_retire, next o_pc=32'h104.
- LW 32'h0040A103 with dmem ack delayed 3 cycles → o_dmem_req held 4 cycles with we=0, WB o_wb_sel=01, total 8 cycles, PC+4.
- BEQ with imm=-8 at PC=32'h200: i_br_taken=1 → PC=32'h1F8 after 3 cycles; i_br_taken=0 → PC=32'h204; no o_rd_we either way.
- JALR with i_alu_result=32'h0000_0303 → PC=32'h302, o_wb_sel=10, o_rd_we one cycle.
- Opcode 7'b1111111: with ILLEGAL_TRAP_EN, o_illegal=1 permanently and no o_imem_req; without it, retire after 3 cycles and PC+4.
- Assert i_rst_n low mid-MEM of a store → o_dmem_req drops the same cycle, no o_retire, PC=RESET_PC, FETCH restarts after release.

Source files
------------

// File: rtl/rv_multicycle_ctrl.sv
// rv_multicycle_ctrl: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for an RV32I core.
// Owns the PC and instruction register, drives the immediate/ALU/writeback selects
// and the instruction/data memory strobes around a combinational datapath.
// Ports:
//   i_clk, i_rst_n                     clock, asynchronous active-low reset
//   o_imem_req, o_pc, i_imem_ack,
//   i_imem_rdata                       instruction fetch port (o_pc is the fetch address)
//   o_instr                            instruction register
//   o_imm_sel, i_imm                   immediate type select / generated immediate
//   o_alu_a_sel, o_alu_b_sel, o_alu_op,
//   i_alu_result, i_br_taken           ALU control, JALR target, branch decision
//   o_dmem_req, o_dmem_we, i_dmem_ack  data memory port
//   o_rd_we, o_wb_sel                  register-file writeback
//   o_retire, o_illegal                retire pulse, illegal-instruction flag
// Build option: define ILLEGAL_TRAP_EN to park illegal opcodes in a TRAP state;
// otherwise they execute as a NOP and o_illegal is tied low.
module rv_multicycle_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_imem_req,
    output logic [31:0] o_pc,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_instr,
    output logic [2:0]  o_imm_sel,
    input  logic [31:0] i_imm,
    output logic        o_alu_a_sel,
    output logic        o_alu_b_sel,
    output logic [3:0]  o_alu_op,
    input  logic [31:0] i_alu_result,
    input  logic        i_br_taken,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    input  logic        i_dmem_ack,
    output logic        o_rd_we,
    output logic [1:0]  o_wb_sel,
    output logic        o_retire,
    output logic        o_illegal
);
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_BR    = 7'b1100011;
    localparam logic [6:0] OPC_LD    = 7'b0000011;
    localparam logic [6:0] OPC_ST    = 7'b0100011;
    localparam logic [6:0] OPC_OPI   = 7'b0010011;
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_FENCE = 7'b0001111;

    typedef enum logic [2:0] {
        FETCH, DECODE, EXEC, MEM, WB
`ifdef ILLEGAL_TRAP_EN
        , TRAP
`endif
    } state_t;

    state_t st;
    logic is_lui, is_auipc, is_jal, is_jalr, is_br, is_ld, is_st, is_opi, is_op, is_fence;
    logic ill, is_nop, retire;
    logic [3:0] dec_op;
    logic [31:0] next_pc;

    // Computed straight from the fetched word so o_imm_sel is already valid in DECODE.
    function automatic logic [2:0] imm_type(input logic [31:0] w);
        case (w[6:0])
            OPC_LUI, OPC_AUIPC: imm_type = 3'b101;
            OPC_JAL:            imm_type = 3'b100;
            OPC_BR:             imm_type = 3'b011;
            OPC_ST:             imm_type = 3'b010;
            OPC_OPI:            imm_type = (w[13:12] == 2'b01) ? 3'b001 : 3'b000;
            default:            imm_type = 3'b000;
        endcase
    endfunction

    assign is_lui   = o_instr[6:0] == OPC_LUI;
    assign is_auipc = o_instr[6:0] == OPC_AUIPC;
    assign is_jal   = o_instr[6:0] == OPC_JAL;
    assign is_jalr  = o_instr[6:0] == OPC_JALR;
    assign is_br    = o_instr[6:0] == OPC_BR;
    assign is_ld    = o_instr[6:0] == OPC_LD;
    assign is_st    = o_instr[6:0] == OPC_ST;
    assign is_opi   = o_instr[6:0] == OPC_OPI;
    assign is_op    = o_instr[6:0] == OPC_OP;
    assign is_fence = o_instr[6:0] == OPC_FENCE;
    assign ill      = !(is_lui || is_auipc || is_jal || is_jalr || is_br || is_ld ||
                        is_st || is_opi || is_op || is_fence);
    // Illegal opcodes only reach EXEC when the trap is not built.
    assign is_nop   = is_fence || ill;

    // funct7[5] only matters for OP and the right-shift immediates.
    assign dec_op = (is_op || (is_opi && o_instr[14:12] == 3'b101)) ? {o_instr[30], o_instr[14:12]} :
                    is_opi ? {1'b0, o_instr[14:12]} : 4'b0000;

    assign next_pc = is_jal ? o_pc + i_imm :
                     is_jalr ? (i_alu_result & ~32'h1) :
                     (is_br && i_br_taken) ? o_pc + i_imm : o_pc + 32'd4;

    // A store finishes on its dmem ack cycle, so retire has to see the ack combinationally.
    assign retire = (st == EXEC && (is_br || is_nop)) ||
                    (st == MEM && is_st && i_dmem_ack) ||
                    (st == WB);
    assign o_retire = retire;

`ifndef ILLEGAL_TRAP_EN
    assign o_illegal = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            st          <= FETCH;
            o_pc        <= RESET_PC;
            o_instr     <= 32'h0000_0013;
            o_imem_req  <= 1'b0;
            o_dmem_req  <= 1'b0;
            o_dmem_we   <= 1'b0;
            o_rd_we     <= 1'b0;
            o_imm_sel   <= 3'b000;
            o_alu_a_sel <= 1'b0;
            o_alu_b_sel <= 1'b0;
            o_alu_op    <= 4'b0000;
            o_wb_sel    <= 2'b00;
`ifdef ILLEGAL_TRAP_EN
            o_illegal   <= 1'b0;
`endif
        end else begin
            o_rd_we <= 1'b0;
            if (retire) begin
                o_pc       <= next_pc;
                o_imem_req <= 1'b1;
                st         <= FETCH;
            end
            case (st)
                FETCH: begin
                    o_imem_req <= 1'b1;
                    if (o_imem_req && i_imem_ack) begin
                        o_imem_req <= 1'b0;
                        o_instr    <= i_imem_rdata;
                        o_imm_sel  <= imm_type(i_imem_rdata);
                        st         <= DECODE;
                    end
                end
                DECODE: begin
`ifdef ILLEGAL_TRAP_EN
                    if (ill) begin
                        st        <= TRAP;
                        o_illegal <= 1'b1;
                    end else begin
`else
                    begin
`endif
                        st          <= EXEC;
                        o_alu_a_sel <= is_auipc;
                        o_alu_b_sel <= is_auipc || is_ld || is_st || is_jalr || is_opi;
                        o_alu_op    <= dec_op;
                    end
                end
                EXEC: begin
                    if (is_ld || is_st) begin
                        st         <= MEM;
                        o_dmem_req <= 1'b1;
                        o_dmem_we  <= is_st;
                    end else if (!(is_br || is_nop)) begin
                        st       <= WB;
                        o_rd_we  <= 1'b1;
                        o_wb_sel <= is_lui ? 2'b11 : (is_jal || is_jalr) ? 2'b10 : 2'b00;
                    end
                end
                MEM: begin
                    if (i_dmem_ack) begin
                        o_dmem_req <= 1'b0;
                        o_dmem_we  <= 1'b0;
                        if (is_ld) begin
                            st       <= WB;
                            o_rd_we  <= 1'b1;
                            o_wb_sel <= 2'b01;
                        end
                    end
                end
                WB: st <= FETCH;
`ifdef ILLEGAL_TRAP_EN
                TRAP: st <= TRAP;
`endif
                default: st <= FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// tb_rv_multicycle_ctrl: bench for rv_multicycle_ctrl driving both memory ports.
module tb_rv_multicycle_ctrl;
    localparam logic [31:0] RPC = 32'h0000_0100;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        o_imem_req;
    logic [31:0] o_pc;
    logic        i_imem_ack = 1'b0;
    logic [31:0] i_imem_rdata = '0;
    logic [31:0] o_instr;
    logic [2:0]  o_imm_sel;
    logic [31:0] i_imm = '0;
    logic        o_alu_a_sel, o_alu_b_sel;
    logic [3:0]  o_alu_op;
    logic [31:0] i_alu_result = '0;
    logic        i_br_taken = 1'b0;
    logic        o_dmem_req, o_dmem_we;
    logic        i_dmem_ack = 1'b0;
    logic        o_rd_we;
    logic [1:0]  o_wb_sel;
    logic        o_retire, o_illegal;

    always #5 i_clk = ~i_clk;

    rv_multicycle_ctrl #(.RESET_PC(RPC)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .o_imem_req(o_imem_req), .o_pc(o_pc), .i_imem_ack(i_imem_ack), .i_imem_rdata(i_imem_rdata),
        .o_instr(o_instr), .o_imm_sel(o_imm_sel), .i_imm(i_imm),
        .o_alu_a_sel(o_alu_a_sel), .o_alu_b_sel(o_alu_b_sel), .o_alu_op(o_alu_op),
        .i_alu_result(i_alu_result), .i_br_taken(i_br_taken),
        .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .i_dmem_ack(i_dmem_ack),
        .o_rd_we(o_rd_we), .o_wb_sel(o_wb_sel), .o_retire(o_retire), .o_illegal(o_illegal)
    );

    typedef struct {
        logic [31:0] ins, imm, alu;
        logic        br;
        int          iw, dw;
        int          cyc;
        logic [31:0] npc;
        int          rdw;
        logic [1:0]  wb;
        logic [2:0]  isel;
        logic        cs, a, b;
        logic [3:0]  op;
        int          dcyc;
        logic        dwe;
    } vec_t;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Expected behaviour of one instruction from its opcode class, memory wait counts and PC.
    function automatic vec_t model(input logic [31:0] ins, imm, alu, input logic br,
                                   input int iw, dw, input logic [31:0] pc);
        vec_t v;
        logic [2:0] f3 = ins[14:12];
        v = '{ins, imm, alu, br, iw, dw, 3 + iw, pc + 32'd4, 0, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 4'b0000, 0, 1'b0};
        case (ins[6:0])
            7'h37: begin v.cyc = 4 + iw; v.rdw = 1; v.wb = 2'b11; v.isel = 3'b101; end
            7'h17: begin v.cyc = 4 + iw; v.rdw = 1; v.isel = 3'b101; v.cs = 1; v.a = 1; v.b = 1; end
            7'h6F: begin v.cyc = 4 + iw; v.rdw = 1; v.wb = 2'b10; v.isel = 3'b100; v.npc = pc + imm; end
            7'h67: begin v.cyc = 4 + iw; v.rdw = 1; v.wb = 2'b10; v.cs = 1; v.b = 1; v.npc = alu & ~32'h1; end
            7'h63: begin v.isel = 3'b011; v.npc = br ? pc + imm : pc + 32'd4; end
            7'h03: begin v.cyc = 5 + iw + dw; v.rdw = 1; v.wb = 2'b01; v.cs = 1; v.b = 1; v.dcyc = dw + 1; end
            7'h23: begin v.cyc = 4 + iw + dw; v.isel = 3'b010; v.cs = 1; v.b = 1; v.dcyc = dw + 1; v.dwe = 1; end
            7'h13: begin
                v.cyc = 4 + iw; v.rdw = 1; v.cs = 1; v.b = 1;
                v.isel = (f3 == 3'd1 || f3 == 3'd5) ? 3'b001 : 3'b000;
                v.op = (f3 == 3'd5) ? {ins[30], f3} : {1'b0, f3};
            end
            7'h33: begin v.cyc = 4 + iw; v.rdw = 1; v.cs = 1; v.op = {ins[30], f3}; end
            default: ;
        endcase
        return v;
    endfunction

    // Serves one instruction through both memory ports and checks what the DUT did.
    task automatic run_one(input vec_t v, input string nm);
        int cyc = 0, rdw = 0, dcyc = 0, iwc = 0;
        bit ret = 0, acked = 0, have_isel = 0, isel_bad = 0, pc_bad = 0;
        logic [1:0] wb = '0;
        logic dwe = 1'b0, a = 1'b0, b = 1'b0, ill = 1'b0;
        logic [2:0] isel = '0, isel0 = '0;
        logic [3:0] op = '0;
        logic [31:0] pc0, ir = '0;
        for (int k = 0; k < 10 && !o_imem_req; k++) @(negedge i_clk);
        pc0 = o_pc;
        for (int k = 0; k < 64 && !ret; k++) begin
            i_imem_rdata = v.ins;
            i_imm = v.imm;
            i_alu_result = v.alu;
            i_br_taken = v.br;
            if (acked) begin
                if (!have_isel) begin isel0 = o_imm_sel; have_isel = 1; end
                else if (o_imm_sel !== isel0) isel_bad = 1;
            end
            i_imem_ack = o_imem_req && iwc == v.iw;
            if (i_imem_ack) acked = 1;
            if (o_imem_req) iwc++;
            i_dmem_ack = o_dmem_req && dcyc == v.dw;
            if (o_dmem_req) begin dcyc++; dwe = o_dmem_we; end
            #1;
            if (o_rd_we) begin rdw++; wb = o_wb_sel; end
            if (o_pc !== pc0) pc_bad = 1;
            cyc++;
            if (o_retire) begin
                ret = 1; isel = o_imm_sel; a = o_alu_a_sel; b = o_alu_b_sel;
                op = o_alu_op; ir = o_instr; ill = o_illegal;
            end
            @(negedge i_clk);
        end
        i_imem_ack = 1'b0;
        i_dmem_ack = 1'b0;
        chk({nm, " retired"}, 32'(ret), 32'd1);
        chk({nm, " cycles"}, cyc, v.cyc);
        chk({nm, " next_pc"}, o_pc, v.npc);
        chk({nm, " pc_hold"}, 32'(pc_bad), 32'd0);
        chk({nm, " rd_we_pulses"}, rdw, v.rdw);
        if (v.rdw > 0) chk({nm, " wb_sel"}, 32'(wb), 32'(v.wb));
        chk({nm, " imm_sel"}, 32'(isel), 32'(v.isel));
        chk({nm, " imm_sel_hold"}, 32'(isel_bad), 32'd0);
        if (v.cs) chk({nm, " alu_sels"}, 32'({a, b}), 32'({v.a, v.b}));
        chk({nm, " alu_op"}, 32'(op), 32'(v.op));
        chk({nm, " dmem_cycles"}, dcyc, v.dcyc);
        if (v.dcyc > 0) chk({nm, " dmem_we"}, 32'(dwe), 32'(v.dwe));
        chk({nm, " instr"}, ir, v.ins);
        chk({nm, " illegal"}, 32'(ill), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_rst_n = 1'b0;
        i_imem_ack = 1'b0;
        i_dmem_ack = 1'b0;
        #1;
        chk("rst_strobes", 32'({o_imem_req, o_dmem_req, o_dmem_we, o_rd_we, o_retire, o_illegal}), 32'd0);
        chk("rst_sels", 32'({o_imm_sel, o_alu_a_sel, o_alu_b_sel, o_alu_op, o_wb_sel}), 32'd0);
        chk("rst_pc", o_pc, RPC);
        chk("rst_ir", o_instr, 32'h0000_0013);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        chk("first_req", 32'(o_imem_req), 32'd1);
    endtask

    initial begin
        vec_t tbl[16];
        vec_t v;
        logic [6:0] opcs[10];
        logic [31:0] mpc, ins;
`ifdef ILLEGAL_TRAP_EN
        int bad = 0;
`endif
        tbl[0]  = '{32'h00500093, 32'd5,        32'd0,   1'b0, 0, 0, 4, 32'h104,      1, 2'b00, 3'b000, 1'b1, 1'b0, 1'b1, 4'b0000, 0, 1'b0};
        tbl[1]  = '{32'h0040A103, 32'd4,        32'd0,   1'b0, 0, 3, 8, 32'h108,      1, 2'b01, 3'b000, 1'b1, 1'b0, 1'b1, 4'b0000, 4, 1'b0};
        tbl[2]  = '{32'h0020A423, 32'd8,        32'd0,   1'b0, 1, 0, 5, 32'h10C,      0, 2'b00, 3'b010, 1'b1, 1'b0, 1'b1, 4'b0000, 1, 1'b1};
        tbl[3]  = '{32'h0F4000EF, 32'h0F4,      32'd0,   1'b0, 0, 0, 4, 32'h200,      1, 2'b10, 3'b100, 1'b0, 1'b0, 1'b0, 4'b0000, 0, 1'b0};
        tbl[4]  = '{32'hFE000CE3, 32'hFFFFFFF8, 32'd0,   1'b1, 0, 0, 3, 32'h1F8,      0, 2'b00, 3'b011, 1'b0, 1'b0, 1'b0, 4'b0000, 0, 1'b0};
        tbl[5]  = '{32'hFE000CE3, 32'hFFFFFFF8, 32'd0,   1'b0, 0, 0, 3, 32'h1FC,      0, 2'b00, 3'b011, 1'b0, 1'b0, 1'b0, 4'b0000, 0, 1'b0};
        tbl[6]  = '{32'h000080E7, 32'd0,        32'h303, 1'b0, 0, 0, 4, 32'h302,      1, 2'b10, 3'b000, 1'b1, 1'b0, 1'b1, 4'b0000, 0, 1'b0};
        tbl[7]  = '{32'h12345037, 32'h12345000, 32'd0,   1'b0, 0, 0, 4, 32'h306,      1, 2'b11, 3'b101, 1'b0, 1'b0, 1'b0, 4'b0000, 0, 1'b0};
        tbl[8]  = '{32'h00001097, 32'h1000,     32'd0,   1'b0, 0, 0, 4, 32'h30A,      1, 2'b00, 3'b101, 1'b1, 1'b1, 1'b1, 4'b0000, 0, 1'b0};
        tbl[9]  = '{32'h402081B3, 32'd0,        32'd0,   1'b0, 0, 0, 4, 32'h30E,      1, 2'b00, 3'b000, 1'b1, 1'b0, 1'b0, 4'b1000, 0, 1'b0};
        tbl[10] = '{32'h4030D093, 32'd3,        32'd0,   1'b0, 0, 0, 4, 32'h312,      1, 2'b00, 3'b001, 1'b1, 1'b0, 1'b1, 4'b1101, 0, 1'b0};
        tbl[11] = '{32'h00209093, 32'd2,        32'd0,   1'b0, 0, 0, 4, 32'h316,      1, 2'b00, 3'b001, 1'b1, 1'b0, 1'b1, 4'b0001, 0, 1'b0};
        tbl[12] = '{32'hFFF0C093, 32'hFFFFFFFF, 32'd0,   1'b0, 0, 0, 4, 32'h31A,      1, 2'b00, 3'b000, 1'b1, 1'b0, 1'b1, 4'b0100, 0, 1'b0};
        tbl[13] = '{32'h0000000F, 32'd0,        32'd0,   1'b0, 2, 0, 5, 32'h31E,      0, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 4'b0000, 0, 1'b0};
        tbl[14] = '{32'h0000006F, 32'hFFFFFCDE, 32'd0,   1'b0, 0, 0, 4, 32'hFFFFFFFC, 1, 2'b10, 3'b100, 1'b0, 1'b0, 1'b0, 4'b0000, 0, 1'b0};
        tbl[15] = '{32'h00000013, 32'd0,        32'd0,   1'b0, 0, 0, 4, 32'h0,        1, 2'b00, 3'b000, 1'b1, 1'b0, 1'b1, 4'b0000, 0, 1'b0};
        opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F};

        do_reset();
        for (int i = 0; i < 16; i++) run_one(tbl[i], $sformatf("v%0d", i));
        mpc = tbl[15].npc;

        for (int i = 0; i < 48; i++) begin
            ins = $urandom();
            ins[6:0] = opcs[$urandom_range(0, 9)];
            v = model(ins, $urandom(), $urandom(), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 3), $urandom_range(0, 3), mpc);
            run_one(v, $sformatf("r%0d", i));
            mpc = v.npc;
        end

`ifdef ILLEGAL_TRAP_EN
        for (int k = 0; k < 10 && !o_imem_req; k++) @(negedge i_clk);
        i_imem_rdata = 32'hFFFF_FFFF;
        i_imem_ack = 1'b1;
        @(negedge i_clk);
        i_imem_ack = 1'b0;
        @(negedge i_clk);
        for (int k = 0; k < 8; k++) begin
            if (!o_illegal || o_imem_req || o_retire || o_dmem_req || o_rd_we) bad++;
            @(negedge i_clk);
        end
        chk("trap_hold", bad, 0);
        chk("trap_pc", o_pc, mpc);
`else
        v = model(32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0, 1, 0, mpc);
        run_one(v, "illegal_nop");
`endif

        do_reset();
        i_imem_rdata = 32'h0020A423;
        i_imm = 32'd8;
        i_imem_ack = 1'b1;
        @(negedge i_clk);
        i_imem_ack = 1'b0;
        for (int k = 0; k < 10 && !o_dmem_req; k++) @(negedge i_clk);
        chk("abort_in_mem", 32'({o_dmem_req, o_dmem_we}), 32'd3);
        @(negedge i_clk);
        #2 i_rst_n = 1'b0;
        #1 chk("abort_req_drop", 32'({o_dmem_req, o_dmem_we, o_retire}), 32'd0);
        @(negedge i_clk);
        chk("abort_pc", o_pc, RPC);
        chk("abort_quiet", 32'({o_rd_we, o_retire, o_imem_req}), 32'd0);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        chk("abort_restart", 32'(o_imem_req), 32'd1);
        v = model(32'h00500093, 32'd5, 32'd0, 1'b0, 0, 0, RPC);
        run_one(v, "post_abort");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
